keypad_matrix_scanner: RTL and testbench
========================================

Name: keypad_matrix_scanner

Overview:
- Reads a 4x4 push-button matrix for time-set input. It is the input-side counterpart of the 4x4 LED row/column multiplexer.
- Drives one row low at a time and samples the four active-low column lines.
- Debounces every key and delivers each key press as a 4-bit code through a valid/ack handshake to the clock-setting logic.
- Key index convention matches the display pixel index: code = row*4 + col.

Parameters:
- SETTLE_CYCLES, 2: clk cycles a row is driven before its columns are sampled. Must be >= 2 to cover the 2-flop synchronizer.
- DEBOUNCE_SCANS, 4: consecutive full scan frames a key's raw state must differ from its debounced state before the debounced state flips. Range 1..15.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; asynchronous, active-high.
- row_n  output  4  row drive, active-low, exactly one bit low while scanning. Row r is driven with bit r low.
- col_n  input  4  column sense, active-low, externally pulled up, asynchronous to clk.
- key_valid  output  1  a press event is held in key_code.
- key_code  output  4  {row[1:0], col[1:0]} of the held event.
- key_ack  input  1  consumer accepts the held event when key_valid && key_ack at a clk edge.
- key_down  output  16  debounced pressed state; bit row*4+col.
- overflow  output  1  sticky: at least one press event was dropped.

Behaviour:
- Reset (async assert): row_n=4'b1111, key_valid=0, key_code=0, key_down=0, overflow=0.
  - All debounce counters, the row counter and the dwell counter clear.
  - Synchronizer flops reset to 4'b1111 (nothing pressed).
  - Reset mid-frame or with an event pending discards everything; no event is emitted on release of reset.
- Scan FSM:
  - First clk edge after rst deasserts enters SCAN with row 0: row_n=4'b1110.
  - Dwell per row is SETTLE_CYCLES+1 cycles. The dwell counter runs 0..SETTLE_CYCLES.
  - At dwell==SETTLE_CYCLES, the synchronized ~col_n is sampled as raw state for keys row*4+0..3. Then the row advances (3 wraps to 0) and dwell clears.
  - Frame length is 4*(SETTLE_CYCLES+1) cycles (12 at default).
- Synchronizer: 2-flop on col_n. The sampled value reflects col_n as of 2 cycles earlier, inside the current row's dwell.
- Debounce, per key, updated only on that key's row sample:
  - raw==debounced: counter clears.
  - raw!=debounced: counter increments. When it reaches DEBOUNCE_SCANS, debounced flips and the counter clears.
  - Counter width 4 bits.
- Events:
  - Debounced 0->1 produces a press event with code {row, col}.
  - 1->0 (release) updates key_down only; no event.
- Multiple simultaneous presses in one row sample: lowest col wins the event. Remaining presses are dropped and set overflow. key_down still updates for all of them.
- Holding register:
  - Event with key_valid=0: next cycle key_valid=1, key_code=code.
  - key_valid && key_ack with no new event: key_valid=0 next cycle.
  - key_valid && key_ack in the same cycle as a new event: key_valid stays 1, key_code takes the new code. Nothing is dropped.
  - key_valid && !key_ack with a new event: event dropped, key_code unchanged, overflow=1.
  - key_ack while key_valid=0: ignored.
- overflow stays set until rst.
- Latency: the event appears one cycle after the row sample that completes debounce.
- key_down is registered and updates in the same cycle as event generation.

Decomposition:
- Shared package constants:
  - NUM_ROWS=4, NUM_COLS=4, KEY_CODE_W=4.
  - Row drive patterns ROW_DRIVE[0..3] = 1110, 1101, 1011, 0111. These are shared with the display multiplexer.
- Sub-module key_debounce (per-key raw/debounced state, counter, rise pulse output) instantiated 16 times.
  - Sample enable = row match && dwell==SETTLE_CYCLES.

Test Plan:
All timing below is at default parameters. The bench models the matrix: col_n[c]=0 iff row_n[r]==0 and key (r,c) is pressed.
- Reset behaviour: assert rst mid-scan -> row_n=1111, key_valid=0, overflow=0 immediately. Release -> row_n sequence 1110,1101,1011,0111 with 3 cycles each, repeating.
- Clean press of key (2,1), held stable -> key_valid rises 37..60 cycles after press with key_code=9 and key_down[9]=1. Ack for one cycle -> key_valid=0 next cycle. Release after ack -> key_down[9]=0 after 4 frames, no new key_valid.
- Bounce: key (0,3) toggles every 5 cycles for 100 cycles, then held -> exactly one event with key_code=3.
- Overflow: press key 3, never ack, then press key 12 -> key_code stays 3, overflow=1. Ack -> key_valid=0, overflow stays 1 until rst.
- Same-row simultaneous press of (1,0) and (1,2) -> one event with key_code=4, key_down[4]=key_down[6]=1, overflow=1.
- Ack coincident with new event: hold key 5 unacked, press key 10, assert key_ack exactly on key 10's event cycle -> key_valid stays 1, key_code=10, overflow=0.

Source files
------------

// File: rtl/keypad_matrix_scanner_pkg.sv
// Shared constants for the 4x4 keypad scanner; row drive patterns are
// common with the LED row/column multiplexer.
package keypad_matrix_scanner_pkg;

  localparam int NUM_ROWS   = 4;
  localparam int NUM_COLS   = 4;
  localparam int NUM_KEYS   = NUM_ROWS * NUM_COLS;
  localparam int KEY_CODE_W = 4;

  // Indexed by row number: row r is driven with bit r low.
  localparam logic [NUM_ROWS-1:0][3:0] ROW_DRIVE = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

  typedef logic [KEY_CODE_W-1:0] key_code_t;

endpackage

// File: rtl/keypad_matrix_scanner_key_debounce.sv
// Per-key debouncer: debounced state flips after DEBOUNCE_SCANS consecutive
// disagreeing samples; o_rise pulses on the sample that completes a press.
module keypad_matrix_scanner_key_debounce #(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_sample,
  input  logic i_raw,
  output logic o_down,
  output logic o_rise
);

  localparam logic [3:0] LIMIT = 4'(DEBOUNCE_SCANS);

  logic [3:0] r_cnt;
  logic       r_down;
  logic       w_flip;

  assign w_flip = i_sample && (i_raw != r_down) && ((r_cnt + 4'd1) == LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= 4'd0;
      r_down <= 1'b0;
    end else if (i_sample) begin
      if (i_raw == r_down) begin
        r_cnt <= 4'd0;
      end else if (w_flip) begin
        r_cnt  <= 4'd0;
        r_down <= ~r_down;
      end else begin
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end

  assign o_down = r_down;
  assign o_rise = w_flip && !r_down;

endmodule

// File: rtl/keypad_matrix_scanner.sv
// 4x4 keypad scanner: row-at-a-time scan, per-key debounce, press events
// delivered through a single-entry valid/ack holding register.
module keypad_matrix_scanner
  import keypad_matrix_scanner_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 2,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [NUM_ROWS-1:0]   row_n,
  input  logic [NUM_COLS-1:0]   col_n,
  output logic                  key_valid,
  output logic [KEY_CODE_W-1:0] key_code,
  input  logic                  key_ack,
  output logic [NUM_KEYS-1:0]   key_down,
  output logic                  overflow
);

  localparam int DW = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SETTLE_CYCLES);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SCAN = 1'b1;

  logic [0:0]          r_state;
  logic [1:0]          r_row;
  logic [DW-1:0]       r_dwell;
  logic [NUM_ROWS-1:0] r_row_n;
  logic [NUM_COLS-1:0] r_sync1;
  logic [NUM_COLS-1:0] r_sync2;
  logic                r_valid;
  key_code_t           r_code;
  logic                r_overflow;

  logic                w_sample_row;
  logic [NUM_KEYS-1:0] w_rise;
  logic [NUM_KEYS-1:0] w_down;
  logic                w_any;
  logic                w_multi;
  key_code_t           w_code;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= col_n;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_row   <= 2'd0;
      r_dwell <= '0;
      r_row_n <= '1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state <= ST_SCAN;
          r_row   <= 2'd0;
          r_dwell <= '0;
          r_row_n <= ROW_DRIVE[0];
        end
        default: begin
          if (r_dwell == DWELL_LAST) begin
            r_dwell <= '0;
            r_row   <= r_row + 2'd1;
            r_row_n <= ROW_DRIVE[r_row + 2'd1];
          end else begin
            r_dwell <= r_dwell + 1'b1;
          end
        end
      endcase
    end
  end

  assign w_sample_row = (r_state == ST_SCAN) && (r_dwell == DWELL_LAST);

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    keypad_matrix_scanner_key_debounce #(
      .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_deb (
      .clk     (clk),
      .rst     (rst),
      .i_sample(w_sample_row && (r_row == 2'(k / NUM_COLS))),
      .i_raw   (~r_sync2[k % NUM_COLS]),
      .o_down  (w_down[k]),
      .o_rise  (w_rise[k])
    );
  end

  // Only one row samples per cycle, so lowest index is lowest column.
  always_comb begin
    w_any   = 1'b0;
    w_multi = 1'b0;
    w_code  = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (w_rise[k]) begin
        if (w_any) begin
          w_multi = 1'b1;
        end else begin
          w_any  = 1'b1;
          w_code = KEY_CODE_W'(k);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_code     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_any) begin
        if (!r_valid || key_ack) begin
          r_valid <= 1'b1;
          r_code  <= w_code;
        end else begin
          r_overflow <= 1'b1;
        end
      end else if (r_valid && key_ack) begin
        r_valid <= 1'b0;
      end
      if (w_multi) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign row_n     = r_row_n;
  assign key_valid = r_valid;
  assign key_code  = r_code;
  assign key_down  = w_down;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Directed bench for keypad_matrix_scanner with a behavioural 4x4 switch matrix.
module tb_keypad_matrix_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_ack = 1'b0;
  logic [15:0] key_down;
  logic        overflow;

  logic [15:0] pressed = '0;
  logic [3:0]  ROWS [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  int n_tests = 0;
  int n_fail  = 0;
  int ev_cnt  = 0;
  logic prev_valid = 1'b0;

  keypad_matrix_scanner dut (
    .clk      (clk),
    .rst      (rst),
    .row_n    (row_n),
    .col_n    (col_n),
    .key_valid(key_valid),
    .key_code (key_code),
    .key_ack  (key_ack),
    .key_down (key_down),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (row_n[r] == 1'b0 && pressed[r*4+c]) col_n[c] = 1'b0;
  end

  always @(negedge clk) begin
    if (key_valid === 1'b1 && prev_valid !== 1'b1) ev_cnt++;
    prev_valid = key_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    while (key_valid !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_valid_timeout", key_valid, 1);
  endtask

  task automatic ack1();
    key_ack = 1'b1;
    @(negedge clk);
    key_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int ev0;
    int g;

    cyc(3);
    check("rst_row_n", row_n, 4'b1111);
    check("rst_valid", key_valid, 0);
    check("rst_code", key_code, 0);
    check("rst_down", key_down, 0);
    check("rst_ovf", overflow, 0);

    rst = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      check("row_seq", row_n, ROWS[(i/3)%4]);
    end

    #2 rst = 1'b1;
    #1;
    check("midrst_row_n", row_n, 4'b1111);
    check("midrst_valid", key_valid, 0);
    check("midrst_ovf", overflow, 0);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    check("post_rst_row0", row_n, 4'b1110);

    // Clean press of key (2,1)
    pressed[9] = 1'b1;
    wait_valid(80, n);
    check("press9_latency_in_range", (n >= 37 && n <= 60), 1);
    check("press9_code", key_code, 9);
    check("press9_down", key_down, 16'h0200);
    ack1();
    check("press9_ack_clears", key_valid, 0);
    pressed[9] = 1'b0;
    ev0 = ev_cnt;
    cyc(60);
    check("release9_down", key_down, 0);
    check("release9_no_event", ev_cnt - ev0, 0);

    // Bouncing key (0,3): never 4 consecutive pressed samples
    ev0 = ev_cnt;
    repeat (20) begin
      pressed[3] = ~pressed[3];
      cyc(5);
    end
    check("bounce_no_event", ev_cnt - ev0, 0);
    check("bounce_down", key_down, 0);
    pressed[3] = 1'b1;
    wait_valid(80, n);
    cyc(40);
    check("bounce_one_event", ev_cnt - ev0, 1);
    check("bounce_code", key_code, 3);
    check("bounce_down3", key_down, 16'h0008);

    // Overflow: key 3 held unacked, then key 12
    pressed[12] = 1'b1;
    cyc(60);
    check("ovf_valid_held", key_valid, 1);
    check("ovf_code_kept", key_code, 3);
    check("ovf_set", overflow, 1);
    check("ovf_down", key_down, 16'h1008);
    ack1();
    check("ovf_ack_clears", key_valid, 0);
    check("ovf_sticky", overflow, 1);
    pressed = '0;
    cyc(60);
    check("ovf_sticky_late", overflow, 1);
    check("ovf_no_event", key_valid, 0);
    do_reset();
    check("ovf_cleared_by_rst", overflow, 0);

    // Same-row simultaneous press of (1,0) and (1,2)
    pressed = 16'h0050;
    wait_valid(80, n);
    check("multi_code", key_code, 4);
    check("multi_down", key_down, 16'h0050);
    check("multi_ovf", overflow, 1);
    ack1();
    pressed = '0;
    cyc(60);
    do_reset();

    // Ack coincident with a new event
    pressed[5] = 1'b1;
    wait_valid(80, n);
    check("coin_first_code", key_code, 5);
    g = 0;
    while (row_n == 4'b0111 && g < 20) begin
      @(negedge clk);
      g++;
    end
    while (row_n != 4'b0111 && g < 40) begin
      @(negedge clk);
      g++;
    end
    check("coin_row3_sync", row_n, 4'b0111);
    // Row 2 samples fall after negedges 11, 23, 35, 47 from here.
    pressed[10] = 1'b1;
    cyc(47);
    check("coin_pre_code", key_code, 5);
    key_ack = 1'b1;
    @(negedge clk);
    key_ack = 1'b0;
    check("coin_valid", key_valid, 1);
    check("coin_code", key_code, 10);
    check("coin_ovf", overflow, 0);
    check("coin_down", key_down, 16'h0420);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
